// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between pc_sequencer, instruction memory, execute-stage branch resolution and the PC.
// The master modport is the sequencer side; the slave modport is the surrounding pipeline/memory side.
interface pc_sequencer_if;
  logic [31:0] new_addr;
  logic        imem_req;
  logic        imem_ack;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        fetch_valid;
  logic        flush;
  logic        trap;

  modport master (
    output new_addr, imem_req, fetch_valid, flush, trap,
    input  imem_ack, stall, br_valid, br_target
  );

  modport slave (
    input  new_addr, imem_req, fetch_valid, flush, trap,
    output imem_ack, stall, br_valid, br_target
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC next-address sequencer: 1-cycle registered new_addr, redirects beat stall/ack, stall parks in HOLD with no request.
// Optional PC_SEQ_ALIGN_CHECK_EN: misaligned redirect targets go to TRAP_VECTOR and pulse trap.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] INCR         = 32'd4,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, REDIRECT} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic        fetch_valid_q, fetch_valid_nxt;
  logic        flush_q, flush_nxt;
  logic        trap_q, trap_nxt;
  logic        squash_q, squash_nxt;
  logic        misaligned;
  logic [31:0] redirect_addr;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign misaligned = (bus.br_target[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign redirect_addr = misaligned ? TRAP_VECTOR : bus.br_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      addr_q        <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      trap_q        <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      addr_q        <= addr_nxt;
      fetch_valid_q <= fetch_valid_nxt;
      flush_q       <= flush_nxt;
      trap_q        <= trap_nxt;
      squash_q      <= squash_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    addr_nxt        = addr_q;
    fetch_valid_nxt = 1'b0;
    flush_nxt       = 1'b0;
    trap_nxt        = 1'b0;
    squash_nxt      = squash_q;

    if (state_q == BOOT) begin
      state_nxt = FETCH;
    end else if (bus.br_valid) begin
      addr_nxt  = redirect_addr;
      flush_nxt = 1'b1;
      trap_nxt  = misaligned;
      state_nxt = REDIRECT;
      // An ack arriving with the redirect retires the outstanding request, so nothing is left to squash.
      if (state_q == FETCH) squash_nxt = !bus.imem_ack;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.imem_ack) begin
            if (squash_q) begin
              squash_nxt = 1'b0;
            end else if (!bus.stall) begin
              addr_nxt        = addr_q + INCR;
              fetch_valid_nxt = 1'b1;
            end else begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.stall) begin
            addr_nxt        = addr_q + INCR;
            fetch_valid_nxt = 1'b1;
            state_nxt       = FETCH;
          end
        end
        REDIRECT: state_nxt = FETCH;
        default:  state_nxt = BOOT;
      endcase
    end
  end

  assign bus.new_addr    = addr_q;
  assign bus.imem_req    = (state_q == FETCH);
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
  assign bus.trap        = trap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change and outputs are checked 1 time unit after each rising edge.
// Redirect-target expectations follow PC_SEQ_ALIGN_CHECK_EN when the bench is built with it.
module tb_pc_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [31:0] a, input logic req,
                      input logic fv, input logic fl, input logic tr);
    check({tag, ".new_addr"}, bus.new_addr, a);
    check({tag, ".imem_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    check({tag, ".fetch_valid"}, {31'd0, bus.fetch_valid}, {31'd0, fv});
    check({tag, ".flush"}, {31'd0, bus.flush}, {31'd0, fl});
    check({tag, ".trap"}, {31'd0, bus.trap}, {31'd0, tr});
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst           = 1'b1;
    bus.imem_ack  = 1'b0;
    bus.stall     = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = 32'h0;
    step();
    step();
    outs("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    outs("boot_exit", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Zero-wait-state streaming.
    bus.imem_ack = 1'b1;
    step(); outs("seq1", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); outs("seq2", 32'h8, 1'b1, 1'b1, 1'b0, 1'b0);

    // Ack under stall parks in HOLD for three cycles.
    bus.stall = 1'b1;
    step(); outs("hold1", 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.imem_ack = 1'b0;
    step(); outs("hold2", 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); outs("hold3", 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.stall = 1'b0;
    step(); outs("release", 32'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); outs("idle", 32'hC, 1'b1, 1'b0, 1'b0, 1'b0);

    // Redirect with a fetch outstanding: the next ack is squashed.
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h40;
    step(); outs("br40", 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.br_valid = 1'b0;
    step(); outs("br40_refetch", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.imem_ack = 1'b1;
    step(); outs("squashed_ack", 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); outs("after_squash", 32'h44, 1'b1, 1'b1, 1'b0, 1'b0);

    // Redirect together with ack and stall: redirect wins, no squash left behind.
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h80;
    bus.stall     = 1'b1;
    step(); outs("br_ack_stall", 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.br_valid = 1'b0;
    bus.imem_ack = 1'b0;
    bus.stall    = 1'b0;
    step(); outs("br80_refetch", 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.imem_ack = 1'b1;
    step(); outs("no_squash", 32'h84, 1'b1, 1'b1, 1'b0, 1'b0);

    // Wrap at the top of the address space (first ack squashed).
    bus.imem_ack  = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'hFFFF_FFFC;
    step(); outs("br_top", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.br_valid = 1'b0;
    step();
    bus.imem_ack = 1'b1;
    step(); outs("top_squash", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); outs("wrap", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Misaligned redirect target; ack alongside avoids a squash.
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h42;
    step();
`ifdef PC_SEQ_ALIGN_CHECK_EN
    outs("br42", 32'h100, 1'b0, 1'b0, 1'b1, 1'b1);
`else
    outs("br42", 32'h42, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    bus.br_valid = 1'b0;
    bus.imem_ack = 1'b0;
    step();
`ifdef PC_SEQ_ALIGN_CHECK_EN
    outs("br42_refetch", 32'h100, 1'b1, 1'b0, 1'b0, 1'b0);
`else
    outs("br42_refetch", 32'h42, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    bus.imem_ack = 1'b1;
    step();
`ifdef PC_SEQ_ALIGN_CHECK_EN
    outs("br42_next", 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    outs("br42_next", 32'h46, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // Reset mid-fetch clears outputs at once; a late ack in BOOT is ignored.
    rst = 1'b1;
    #1;
    outs("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step(); outs("late_ack_boot", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); outs("post_rst_fetch", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
